imem_loader: RTL and testbench

Boot-time writer for the core's instruction memory. It accepts a byte stream over a valid/ready handshake and packs each group of bytes into a little-endian instruction word. It drives the memory's write port with word-aligned byte addresses from 0 upward, and holds the processor core stalled until the programmed word count has been written. It sits between the host/debug byte source and the write port of the instruction memory.

---
 rtl/imem_loader.sv | 165 ++++++++++++++++
 tb/tb_imem_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: packs a byte stream into little-endian
// words, writes them from address 0 upward and holds the core until finished.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; core runs, no bytes accepted
// S_RECV  | accepting bytes into the assembly register
// S_WRITE | one-cycle write of the assembled word to instruction memory
// S_DONE  | one-cycle completion pulse, core still held
module imem_loader #(
    parameter int INS_ADDRESS = 9,
    parameter int DATA_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [INS_ADDRESS-2:0] load_len,
    input  logic                   in_valid,
    input  logic [7:0]             in_byte,
    output logic                   in_ready,
    output logic                   we,
    output logic [INS_ADDRESS-1:0] wa,
    output logic [DATA_W-1:0]      wd,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done
);

    localparam int BPW = DATA_W / 8;
    localparam int WIW = INS_ADDRESS - 2;
    localparam int LW  = INS_ADDRESS - 1;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [LW-1:0]  MAX_WORDS = {1'b1, {WIW{1'b0}}};
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [LW-1:0]      len_q;
    logic [LW-1:0]      len_clamped;
    logic [WIW-1:0]     word_idx_q;
    logic [BCW-1:0]     byte_cnt_q;
    logic [DATA_W-1:0]  asm_q;
    logic [DATA_W-1:0]  asm_next;
    logic [INS_ADDRESS-1:0] wa_q;
    logic [DATA_W-1:0]  wd_q;
    logic               accept;
    logic               last_byte;
    logic               last_word;

    // Clamping keeps word_idx from wrapping, so wa never revisits address 0.
    assign len_clamped = (load_len > MAX_WORDS) ? MAX_WORDS : load_len;
    assign accept      = (state_q == S_RECV) && in_valid;
    assign last_byte   = (byte_cnt_q == LAST_BYTE);
    assign last_word   = ({1'b0, word_idx_q} == (len_q - LW'(1)));

    always_comb begin
        asm_next = asm_q;
        asm_next[8*byte_cnt_q +: 8] = in_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len_clamped == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (accept && last_byte) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = last_word ? S_DONE : S_RECV;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        we       = 1'b0;
        cpu_hold = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_RECV: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: begin
                we       = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    // Write address/data are captured with the final byte so they hold after WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            wa_q       <= '0;
            wd_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q      <= len_clamped;
                        word_idx_q <= '0;
                        byte_cnt_q <= '0;
                    end
                end
                S_RECV: begin
                    if (accept) begin
                        asm_q <= asm_next;
                        if (last_byte) begin
                            byte_cnt_q <= '0;
                            wa_q       <= {word_idx_q, 2'b00};
                            wd_q       <= asm_next;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BCW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (!last_word) begin
                        word_idx_q <= word_idx_q + WIW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign wa = wa_q;
    assign wd = wd_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as whole words
// are fed, and popped when the loader pulses we.
module tb_imem_loader;

    localparam int IA  = 9;
    localparam int DW  = 32;
    localparam int BPW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [IA-2:0] load_len = '0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_byte = '0;
    logic          in_ready;
    logic          we;
    logic [IA-1:0] wa;
    logic [DW-1:0] wd;
    logic          cpu_hold;
    logic          busy;
    logic          done;

    imem_loader #(.INS_ADDRESS(IA), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .load_len (load_len),
        .in_valid (in_valid),
        .in_byte  (in_byte),
        .in_ready (in_ready),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [IA-1:0] exp_wa_q[$];
    logic [DW-1:0] exp_wd_q[$];
    logic [7:0]    src_q[$];
    logic [IA-1:0] exp_addr;

    int            we_cnt = 0;
    int            done_cnt = 0;
    int            hold_cnt = 0;
    int            done_lbl = 0;
    int            we_lbl = 0;
    int            prev_we_lbl = 0;
    logic [IA-1:0] last_wa = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Cycle label: the cycle ending at posedge number cyc+1.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_hold) hold_cnt++;
            if (done) begin
                done_cnt++;
                done_lbl = cyc + 1;
            end
            if (we) begin
                we_cnt++;
                prev_we_lbl = we_lbl;
                we_lbl = cyc + 1;
                last_wa = wa;
                if (exp_wa_q.size() == 0) begin
                    check("spurious_we", 32'(wa), 32'h0);
                    check("spurious_we_any", 32'd1, 32'd0);
                end else begin
                    check("sb_wa", 32'(wa), 32'(exp_wa_q.pop_front()));
                    check("sb_wd", wd, exp_wd_q.pop_front());
                end
            end
        end
    end

    task automatic start_load(input int len, output int t);
        @(negedge clk);
        start = 1'b1;
        load_len = (IA-1)'(len);
        t = cyc + 1;
        exp_addr = '0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds n bytes from src_q; stall=1 drives in_valid as 1,0,0,1,0,0,...
    task automatic feed(input int n, input bit stall, input int pulse_at);
        int i;
        int got;
        logic [DW-1:0] acc;
        i = 0;
        got = 0;
        acc = '0;
        while (got < n && i < n * 4 + 60) begin
            in_valid = stall ? (i % 3 == 0) : 1'b1;
            in_byte  = src_q[0];
            if (pulse_at >= 0) begin
                start = (i == pulse_at);
                load_len = 8'd5;
            end
            #1;
            if (in_valid && in_ready) begin
                acc[8*(got % BPW) +: 8] = src_q.pop_front();
                if (got % BPW == BPW - 1) begin
                    exp_wa_q.push_back(exp_addr);
                    exp_wd_q.push_back(acc);
                    exp_addr = exp_addr + IA'(4);
                end
                got++;
            end
            @(negedge clk);
            i++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("feed_complete", 32'(got), 32'(n));
    endtask

    task automatic wait_done(input int d0);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("done_seen", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_we"},       32'(we),       32'd0);
        check({tag, "_hold"},     32'(cpu_hold), 32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_wa"},       32'(wa),       32'd0);
        check({tag, "_wd"},       wd,            32'd0);
    endtask

    task automatic load_prog_bytes();
        src_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h80, 8'h00};
    endtask

    initial begin
        int t;
        int w0;
        int d0;
        int h0;

        #12;
        check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Two-word load, continuous stream
        load_prog_bytes();
        h0 = hold_cnt; w0 = we_cnt; d0 = done_cnt;
        start_load(2, t);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready", 32'(in_ready), 32'd1);
        feed(8, 1'b0, -1);
        wait_done(d0);
        check("t1_we1_cyc", 32'(prev_we_lbl), 32'(t + 5));
        check("t1_we2_cyc", 32'(we_lbl), 32'(t + 10));
        check("t1_done_cyc", 32'(done_lbl), 32'(t + 11));
        @(negedge clk); #2;
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_hold_cycles", 32'(hold_cnt - h0), 32'd11);
        check("t1_we_count", 32'(we_cnt - w0), 32'd2);

        // Stalled source
        load_prog_bytes();
        w0 = we_cnt; d0 = done_cnt;
        start_load(2, t);
        feed(8, 1'b1, -1);
        wait_done(d0);
        check("t2_we_count", 32'(we_cnt - w0), 32'd2);
        check("t2_done_after_write", 32'(done_lbl), 32'(we_lbl + 1));
        check("t2_sb_empty", 32'(exp_wa_q.size()), 32'd0);

        // Reset mid-word, then a fresh one-word load
        src_q = '{8'h11, 8'h22, 8'h44, 8'h55};
        w0 = we_cnt;
        start_load(2, t);
        feed(2, 1'b0, -1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("t3_no_write", 32'(we_cnt - w0), 32'd0);
        src_q = '{8'h33, 8'h0E, 8'h10, 8'h00};
        d0 = done_cnt;
        start_load(1, t);
        feed(4, 1'b0, -1);
        wait_done(d0);
        check("t3_last_wa", 32'(last_wa), 32'h0);
        check("t3_we_count", 32'(we_cnt - w0), 32'd1);

        // Zero-length load
        h0 = hold_cnt; w0 = we_cnt; d0 = done_cnt;
        start_load(0, t);
        check("t4_done", 32'(done), 32'd1);
        check("t4_hold", 32'(cpu_hold), 32'd1);
        @(negedge clk); #2;
        check("t4_busy_t2", 32'(busy), 32'd0);
        check("t4_hold_t2", 32'(cpu_hold), 32'd0);
        check("t4_done_cyc", 32'(done_lbl), 32'(t + 1));
        check("t4_hold_cycles", 32'(hold_cnt - h0), 32'd1);
        check("t4_no_we", 32'(we_cnt - w0), 32'd0);

        // Bytes in IDLE are not consumed; start during RECV is ignored
        in_valid = 1'b1;
        in_byte = 8'hAA;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("t5_idle_ready", 32'(in_ready), 32'd0);
        end
        src_q = '{8'h33, 8'h0E, 8'h10, 8'h00};
        w0 = we_cnt; d0 = done_cnt;
        start_load(1, t);
        feed(4, 1'b0, 2);
        wait_done(d0);
        repeat (8) @(negedge clk);
        #2;
        check("t5_we_count", 32'(we_cnt - w0), 32'd1);
        check("t5_busy_idle", 32'(busy), 32'd0);

        // Length clamp: 200 requested, 128 written
        for (int k = 0; k < 128 * BPW; k++) src_q.push_back(8'((k * 7 + 3) & 255));
        w0 = we_cnt; d0 = done_cnt;
        start_load(200, t);
        feed(128 * BPW, 1'b0, -1);
        wait_done(d0);
        check("t6_we_count", 32'(we_cnt - w0), 32'd128);
        check("t6_last_wa", 32'(last_wa), 32'h1FC);
        check("t6_done_cyc", 32'(done_lbl), 32'(we_lbl + 1));
        repeat (10) @(negedge clk);
        #2;
        check("t6_no_extra_we", 32'(we_cnt - w0), 32'd128);
        check("t6_sb_empty", 32'(exp_wa_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
